// File: rtl/alu_writeback.sv
// Execute->writeback stage: commits ALU flags, buffers register-file writes in a
// 2-entry FIFO and evaluates branch conditions against the committed flags.
module alu_writeback #(
    parameter int WIDTH  = 16,
    parameter int REGSEL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_result,
    input  logic [3:0]        in_cc,
    input  logic [REGSEL-1:0] in_rd,
    input  logic              in_wr_reg,
    input  logic              in_set_cc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [REGSEL-1:0] out_rd,
    input  logic              flush,
    output logic [3:0]        flags,
    input  logic [2:0]        cond_sel,
    output logic              cond_true
);

    logic [1:0]        count;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [3:0]        flags_q;
    logic [WIDTH-1:0]  mem_result [2];
    logic [REGSEL-1:0] mem_rd     [2];

    logic accept;
    logic push;
    logic pop;

    assign in_ready  = rst_n && !flush && (count != 2'd2);
    assign accept    = in_valid && in_ready;
    assign push      = accept && in_wr_reg;
    assign out_valid = rst_n && (count != 2'd0);
    assign pop       = out_valid && out_ready;

    assign out_result = (count != 2'd0) ? mem_result[rd_ptr] : '0;
    assign out_rd     = (count != 2'd0) ? mem_rd[rd_ptr]     : '0;
    assign flags      = flags_q;

    // Control state; flush also suppresses accept, so a flushed beat never touches flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            flags_q <= 4'b0000;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (accept && in_set_cc) begin
                flags_q <= in_cc;
            end
        end
    end

    // Storage needs no reset; entries are only read while count says they are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr] <= in_result;
            mem_rd[wr_ptr]     <= in_rd;
        end
    end

    always_comb begin
        cond_true = 1'b1;
        case (cond_sel)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flags_q[2];
            3'b010:  cond_true = !flags_q[2];
            3'b011:  cond_true = flags_q[3] ^ flags_q[0];
            3'b100:  cond_true = !(flags_q[3] ^ flags_q[0]);
            3'b101:  cond_true = flags_q[1];
            3'b110:  cond_true = !flags_q[1];
            3'b111:  cond_true = flags_q[3];
            default: cond_true = 1'b1;
        endcase
    end

    a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !flush) |=> ($stable(out_result) && $stable(out_rd)));

    a_count_max: assert property (@(posedge clk) count <= 2'd2);

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: directed scenarios followed by random traffic
// checked against a queue-based reference model.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_result = '0;
    logic [3:0]  in_cc = '0;
    logic [3:0]  in_rd = '0;
    logic        in_wr_reg = 1'b0;
    logic        in_set_cc = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [3:0]  out_rd;
    logic        flush = 1'b0;
    logic [3:0]  flags;
    logic [2:0]  cond_sel = '0;
    logic        cond_true;

    alu_writeback #(.WIDTH(16), .REGSEL(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_cc(in_cc), .in_rd(in_rd), .in_wr_reg(in_wr_reg), .in_set_cc(in_set_cc),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .flush(flush), .flags(flags),
        .cond_sel(cond_sel), .cond_true(cond_true)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  rd;
    } ent_t;

    ent_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         mdl_cnt = 0;
    logic [3:0] mdl_flags = 4'b0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cond_ref(input logic [2:0] sel, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (sel)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return n != v;
            3'd4: return n == v;
            3'd5: return c;
            3'd6: return !c;
            default: return n;
        endcase
    endfunction

    // Monitor: at the negedge the inputs for the coming edge are settled, so a
    // pop seen here happens at the next posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
            if (out_valid && sb_q.size() != 0) begin
                chk("out_result", {16'd0, out_result}, {16'd0, sb_q[0].res});
                chk("out_rd", {28'd0, out_rd}, {28'd0, sb_q[0].rd});
                if (out_ready) void'(sb_q.pop_front());
            end else if (!out_valid) begin
                chk("empty_head", {12'd0, out_rd, out_result}, 32'd0);
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] res, input logic [3:0] rd,
                        input logic wr, input logic setcc, input logic [3:0] cc,
                        input logic ordy, input logic fl, input logic [2:0] sel,
                        output logic acc);
        logic exp_rdy;
        logic do_push;
        logic do_pop;
        @(posedge clk); #1;
        in_valid = v; in_result = res; in_rd = rd; in_wr_reg = wr;
        in_set_cc = setcc; in_cc = cc; out_ready = ordy; flush = fl; cond_sel = sel;
        @(negedge clk); #1;
        exp_rdy = !fl && (mdl_cnt != 2);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("flags", {28'd0, flags}, {28'd0, mdl_flags});
        chk("cond_true", {31'd0, cond_true}, {31'd0, cond_ref(sel, mdl_flags)});
        acc = v && exp_rdy;
        if (fl) begin
            sb_q.delete();
            mdl_cnt = 0;
        end else begin
            do_push = acc && wr;
            do_pop  = (mdl_cnt != 0) && ordy;
            if (do_push) sb_q.push_back('{res: res, rd: rd});
            mdl_cnt = mdl_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
            if (acc && setcc) mdl_flags = cc;
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 4'h0, ordy, 1'b0, 3'($urandom_range(0, 7)), a);
    endtask

    task automatic send(input logic [15:0] res, input logic [3:0] rd, input logic wr,
                        input logic setcc, input logic [3:0] cc, input logic ordy);
        logic a;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, res, rd, wr, setcc, cc, ordy, 1'b0, 3'($urandom_range(0, 7)), a);
            if (a) return;
        end
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_cond(input logic [2:0] sel, input logic exp);
        cond_sel = sel; #1;
        chk("cond_sel", {31'd0, cond_true}, {31'd0, exp});
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        sb_q.delete();
        mdl_cnt = 0;
        mdl_flags = 4'b0000;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic a;
        do_reset(3);
        idle(1, 1'b1);
        check_cond(3'b000, 1'b1);
        check_cond(3'b001, 1'b0);
        check_cond(3'b101, 1'b0);
        check_cond(3'b111, 1'b0);

        send(16'h1234, 4'd3, 1'b1, 1'b1, 4'b1000, 1'b1);
        idle(1, 1'b1);
        chk("flags_after_push", {28'd0, flags}, 32'h8);
        check_cond(3'b011, 1'b1);
        check_cond(3'b111, 1'b1);
        idle(2, 1'b1);

        step(1'b1, 16'hAAAA, 4'd1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, a);
        step(1'b1, 16'hBBBB, 4'd2, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, a);
        step(1'b1, 16'hCCCC, 4'd4, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, a);
        chk("full_blocks", {31'd0, a}, 32'd0);
        step(1'b1, 16'hCCCC, 4'd4, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 3'd0, a);
        chk("full_pop_blocks", {31'd0, a}, 32'd0);
        step(1'b1, 16'hCCCC, 4'd4, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 3'd0, a);
        chk("accept_after_pop", {31'd0, a}, 32'd1);
        idle(4, 1'b1);

        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 16'(i), 4'(i), 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 3'd0, a);
            chk("stream_accept", {31'd0, a}, 32'd1);
        end
        idle(3, 1'b1);

        send(16'h5555, 4'd7, 1'b0, 1'b1, 4'b0100, 1'b1);
        idle(1, 1'b1);
        check_cond(3'b001, 1'b1);
        check_cond(3'b010, 1'b0);

        send(16'h0101, 4'd1, 1'b1, 1'b0, 4'h0, 1'b0);
        send(16'h0202, 4'd2, 1'b1, 1'b0, 4'h0, 1'b0);
        step(1'b1, 16'h7777, 4'd9, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b1, 3'd5, a);
        idle(1, 1'b1);
        chk("flags_after_flush", {28'd0, flags}, 32'h4);

        send(16'h0303, 4'd3, 1'b1, 1'b1, 4'b1111, 1'b0);
        send(16'h0404, 4'd4, 1'b1, 1'b0, 4'h0, 1'b0);
        idle(1, 1'b1);
        do_reset(1);
        idle(1, 1'b1);
        chk("flags_after_reset", {28'd0, flags}, 32'h0);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), 4'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0),
                 3'($urandom_range(0, 7)), a);
        end
        idle(4, 1'b1);
        chk("drained", {31'd0, sb_q.size() != 0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
